keccak_hash_arbiter: RTL
========================

Name: keccak_hash_arbiter

Overview:
- Shares one Keccak512 hash core (padder + f_permutation, 64-bit word input) between NREQ requesters in the integrity unit, e.g. tree-path verifier and bucket-hash updater.
- Grants the core to one requester per message in round-robin order and pulses the core reset before each message so padder state is clean.
- Streams the granted requester's words into the core, then captures the digest and returns it with a one-cycle response strobe to that requester.

Parameters:
NREQ, 4, number of requesters (2..8)
IW, 64, message word width; matches core input width
HW, 512, digest width captured from core output
IDW, 3, width of grant index; must satisfy 2^IDW >= NREQ

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester word valid
req_data  in  NREQ*IW  per-requester word; requester k occupies slice [k*IW +: IW]
req_last  in  NREQ  word is final word of message
req_bytes  in  NREQ*4  valid bytes in last word (1..8); ignored unless req_last
req_ack  out  NREQ  one-hot; word of that requester consumed this cycle
rsp_valid  out  NREQ  one-hot one-cycle digest strobe
rsp_hash  out  HW  digest; valid while rsp_valid is high, held until the next capture
busy  out  1  core owned by a requester (state != IDLE)
grant_id  out  IDW  index of current owner
core_reset  out  1  synchronous reset pulse to hash core
core_in  out  IW  word to core
core_in_ready  out  1  word valid to core
core_is_last  out  1  last-word flag to core
core_byte_num  out  4  byte count to core
core_buffer_full  in  1  core padder full; no word accepted
core_out  in  HW  core digest
core_out_ready  in  1  digest valid

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, grant_id=0, rsp_hash=0. All strobes and core_* outputs are 0, except core_reset=1 while reset is high.
- State IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ.
  - The first set bit wins: latch grant_id, go to CLR.
  - If there are no requests, stay in IDLE.
- State CLR: core_reset=1 for exactly one cycle; no word is accepted. Next state is FEED.
- State FEED:
  - core_in, core_is_last and core_byte_num are driven combinationally from the grant_id slice.
  - core_in_ready = req_valid[grant_id] & ~core_buffer_full.
  - A word transfers when core_in_ready=1. In that cycle req_ack[grant_id]=1; zero latency, same cycle.
  - If the transferred word has req_last=1, go to WAIT.
  - A deasserted req_valid stalls FEED indefinitely. Ownership is not revoked mid-message.
  - Other requesters see req_ack=0 throughout.
- State WAIT:
  - core_in_ready=0.
  - On core_out_ready=1: register core_out into rsp_hash and go to RESP.
- State RESP:
  - rsp_valid[grant_id]=1 for one cycle.
  - rr_ptr <= (grant_id+1) mod NREQ.
  - Next state is IDLE. A new grant is earliest in the following cycle, so the minimum gap between messages is IDLE+CLR = 2 cycles.
- Latency, single-word message:
  - grant (IDLE) -> CLR -> word accepted in FEED -> core latency -> capture in WAIT -> rsp_valid the next cycle.
  - The block itself adds 4 cycles around core latency.
- Requests arriving while busy are held by the requester (valid stays high). They are arbitrated in the next IDLE.
- A simultaneous req_last word and core_buffer_full=1: the word is not accepted and the block stays in FEED.
- A core_out_ready seen in FEED (spurious) is ignored.
- rr_ptr wraps from NREQ-1 to 0. grant_id is only meaningful when busy=1.
- Reset mid-operation:
  - All state is dropped and core_reset is asserted.
  - No rsp_valid is produced for the aborted message.
  - Requesters must restart the message from its first word.

Test Plan:
- Single requester: requester 0 sends 3 words (0x11.., 0x22.., 0x33.. with last, bytes=8). Required: req_ack[0] high on 3 cycles; one core_reset pulse before the first word; rsp_valid=4'b0001 exactly once; rsp_hash equals core_out.
- Fairness: all 4 req_valid held high, 1-word messages each. Required: grant order 0,1,2,3,0; each rsp_valid one-hot in that order; no starvation.
- Backpressure: hold core_buffer_full=1 for 5 cycles mid-message. Required: req_ack=0 during those cycles; no word lost or duplicated; the word sequence seen by the core is identical to the sent one.
- Requester stall: requester 2 drops req_valid for 10 cycles mid-message while requester 1 requests. Required: grant_id stays 2; requester 1 is granted only after rsp_valid[2].
- Wrap: rr_ptr=3 with requests on 0 and 3. Required: 3 is granted first, then 0; rr_ptr returns to 0 and then 1.
- Reset mid-FEED: assert reset after 1 word. Required: outputs are immediately at reset values; no rsp_valid; the next message hashes correctly, with rsp_hash matching the reference model digest.

Source files
------------

// File: rtl/keccak_hash_arbiter.sv
// keccak_hash_arbiter
// -------------------
// Shares one Keccak512 hash core (padder + f_permutation, 64-bit word input)
// between NREQ requesters. One requester owns the core per message. Owners
// are chosen in round-robin order. The core is given a one-cycle reset before
// each message so that the padder starts clean. The owner's words are streamed
// into the core, and the digest is returned to the owner with a one-cycle
// strobe.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   req_valid[k]      requester k presents a word
//   req_data          requester k word in slice [k*IW +: IW]
//   req_last[k]       presented word is the final word of the message
//   req_bytes         requester k valid byte count in slice [k*4 +: 4]
//   req_ack[k]        word of requester k consumed this cycle (one-hot)
//   rsp_valid[k]      one-cycle digest strobe to requester k (one-hot)
//   rsp_hash          last captured digest, held until the next capture
//   busy              core owned by a requester
//   grant_id          index of the current owner (meaningful while busy)
//   core_reset        reset pulse to the hash core
//   core_in, core_in_ready, core_is_last, core_byte_num   word port to core
//   core_buffer_full  core padder cannot take a word this cycle
//   core_out, core_out_ready                              digest from core

module keccak_hash_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 64,
  parameter int HW   = 512,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*IW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*4-1:0] req_bytes,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [HW-1:0]     rsp_hash,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              core_reset,
  output logic [IW-1:0]     core_in,
  output logic              core_in_ready,
  output logic              core_is_last,
  output logic [3:0]        core_byte_num,
  input  logic              core_buffer_full,
  input  logic [HW-1:0]     core_out,
  input  logic              core_out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_nxt;

  // Round-robin search
  // The request vector is rotated so that bit 0 is the requester at rr_ptr.
  // The lowest set bit in the rotated vector is the winner. Its offset is
  // then added back to rr_ptr, modulo NREQ.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              found;
  logic [IDW:0]      win_off;
  logic [IDW:0]      win_sum;
  logic [IDW-1:0]   win_id;

  // NOTE: every signal assigned in an always_comb block gets a default value
  // at the top of the block. Without that default, a path that does not
  // assign the signal infers a latch.
  always_comb begin
    req_dbl = {req_valid, req_valid};
    req_rot = NREQ'(req_dbl >> rr_ptr);
    found   = 1'b0;
    win_off = '0;
    // The loop runs downward, so the lowest set offset is the last one written.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found   = 1'b1;
        win_off = (IDW + 1)'(j);
      end
    end
    win_sum = {1'b0, rr_ptr} + win_off;
    if (win_sum >= (IDW + 1)'(NREQ)) begin
      win_sum = win_sum - (IDW + 1)'(NREQ);
    end
    win_id = win_sum[IDW-1:0];
  end

  // Owner slice selection
  // The comparison loop avoids indexing the vectors with grant_id, which is
  // wider than log2(NREQ) bits.
  logic [NREQ-1:0] grant_onehot;
  logic            sel_valid;
  logic            sel_last;
  logic [IW-1:0]   sel_data;
  logic [3:0]      sel_bytes;

  always_comb begin
    grant_onehot = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    sel_data     = '0;
    sel_bytes    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        grant_onehot[k] = 1'b1;
        sel_valid       = req_valid[k];
        sel_last        = req_last[k];
        sel_data        = req_data[k*IW +: IW];
        sel_bytes       = req_bytes[k*4 +: 4];
      end
    end
  end

  // The next round-robin start is one past the owner that was just served.
  assign rr_ptr_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  // FSM: next state and outputs
  always_comb begin
    state_nxt     = state;
    req_ack       = '0;
    rsp_valid     = '0;
    core_in       = '0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    // The core is also held in reset while the block itself is in reset.
    core_reset    = reset;
    unique case (state)
      S_IDLE: begin
        if (found) state_nxt = S_CLR;
      end
      S_CLR: begin
        core_reset = 1'b1;
        state_nxt  = S_FEED;
      end
      S_FEED: begin
        core_in       = sel_data;
        core_is_last  = sel_last;
        core_byte_num = sel_bytes;
        core_in_ready = sel_valid & ~core_buffer_full;
        req_ack       = grant_onehot & {NREQ{core_in_ready}};
        if (core_in_ready && sel_last) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_out_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = grant_onehot;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // therefore update together on the clock edge, whatever order the
  // statements appear in.
  // NOTE: rsp_hash is a wide register, but it is still reset. Requesters can
  // see its value, so after a reset it must read as zero rather than as the
  // digest of an aborted message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      rsp_hash <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && found)          grant_id <= win_id;
      if (state == S_WAIT && core_out_ready) rsp_hash <= core_out;
      if (state == S_RESP)                   rr_ptr   <= rr_ptr_nxt;
    end
  end

endmodule
